// File: rtl/alu_exec_pkg.sv
// Shared opcode, state and helper definitions for the ALU execute/writeback stage.
package alu_exec_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    // Opcodes from here upward are accepted but never write
    localparam logic [3:0] OP_NOP_MIN = 4'd9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // Single-cycle ops that produce a register write
    function automatic logic is_alu_op(input logic [3:0] op);
        return op < OP_MUL;
    endfunction

endpackage

// File: rtl/alu_exec_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, data_width steps.
// done/product are combinational during the last step so the caller can
// register the result on the same edge that finishes the multiply.
module seq_multiplier #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [data_width-1:0] mcand_in,
    input  logic [data_width-1:0] mplier_in,
    output logic                  done,
    output logic [data_width-1:0] product
);
    localparam int CW = $clog2(data_width);

    logic                  active;
    logic [data_width-1:0] mcand;
    logic [data_width-1:0] mplier;
    logic [data_width-1:0] acc;
    logic [CW-1:0]         cnt;
    logic [data_width-1:0] acc_nxt;

    assign acc_nxt = mplier[0] ? acc + mcand : acc;
    assign done    = active && (cnt == CW'(data_width - 1));
    assign product = acc_nxt;

    // Load on start, then shift/accumulate once per edge until the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            cnt    <= '0;
        end else if (active) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) active <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute/writeback stage feeding the register file write port.
// Optional macro ALU_EXEC_MUL_EN adds the iterative MUL (opcode 8); without it
// opcode 8 is a one-cycle NOP and busy is tied low.
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int data_width   = 32,
    parameter int select_width = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              opcode,
    input  logic [data_width-1:0]   operand_a,
    input  logic [data_width-1:0]   operand_b,
    input  logic [select_width-1:0] dest_addr,
    output logic [data_width-1:0]   write_data_out,
    output logic [select_width-1:0] write_address_out,
    output logic                    reg_write_out,
    output logic                    busy
);
    logic                  accept;
    logic [data_width-1:0] alu_res;

    assign accept = in_valid && in_ready;

    // Single-cycle ALU datapath
    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = operand_a + operand_b;
            OP_SUB:  alu_res = operand_a - operand_b;
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_SLT:  alu_res = {{(data_width-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLL:  alu_res = operand_a << operand_b[4:0];
            OP_SRL:  alu_res = operand_a >> operand_b[4:0];
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    state_t                  state, state_nxt;
    logic                    mul_start;
    logic                    mul_done;
    logic [data_width-1:0]   mul_prod;
    logic [select_width-1:0] mul_dest;

    assign in_ready  = rst_n && (state == S_IDLE);
    assign busy      = (state == S_MUL);
    assign mul_start = accept && (opcode == OP_MUL);

    seq_multiplier #(.data_width(data_width)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mul_start),
        .mcand_in (operand_a),
        .mplier_in(operand_b),
        .done     (mul_done),
        .product  (mul_prod)
    );

    // State register and the destination held across the multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mul_dest <= '0;
        end else begin
            state <= state_nxt;
            if (mul_start) mul_dest <= dest_addr;
        end
    end

    // Next state: stall in S_MUL until the multiplier's final step
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mul_start) state_nxt = S_MUL;
            S_MUL:   if (mul_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end
`else
    assign in_ready = rst_n;
    assign busy     = 1'b0;
`endif

    // Registered write port; the write strobe is a one-cycle pulse per result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_data_out    <= '0;
            write_address_out <= '0;
            reg_write_out     <= 1'b0;
        end else begin
            reg_write_out <= 1'b0;
            if (accept && is_alu_op(opcode)) begin
                write_data_out    <= alu_res;
                write_address_out <= dest_addr;
                reg_write_out     <= (dest_addr != '0);
            end
`ifdef ALU_EXEC_MUL_EN
            else if (mul_done) begin
                write_data_out    <= mul_prod;
                write_address_out <= mul_dest;
                reg_write_out     <= (mul_dest != '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_alu_exec_stage;
    localparam int DW = 32;
    localparam int SW = 5;
`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    opcode = '0;
    logic [DW-1:0] operand_a = '0;
    logic [DW-1:0] operand_b = '0;
    logic [SW-1:0] dest_addr = '0;
    logic [DW-1:0] write_data_out;
    logic [SW-1:0] write_address_out;
    logic          reg_write_out;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    alu_exec_stage #(.data_width(DW), .select_width(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .dest_addr(dest_addr), .write_data_out(write_data_out),
        .write_address_out(write_address_out), .reg_write_out(reg_write_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_left = 0;      // stall cycles remaining for an in-flight MUL
    logic [DW-1:0] m_mres = '0;
    logic [SW-1:0] m_mdst = '0;
    logic          m_rw = 1'b0;
    logic [DW-1:0] m_wd = '0;
    logic [SW-1:0] m_wa = '0;

    function automatic logic [DW-1:0] ref_alu(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ($signed(a) < $signed(b)) ? 1 : 0;
            6: return a << sh;
            7: return a >> sh;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [63:0] p;
        if (!rst_n) begin
            m_left = 0; m_rw = 0; m_wd = '0; m_wa = '0;
        end else begin
            m_rw = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_wd = m_mres; m_wa = m_mdst; m_rw = (m_mdst != 0);
                end
            end else if (in_valid) begin
                if (opcode <= 4'd7) begin
                    m_wd = ref_alu(int'(opcode), operand_a, operand_b);
                    m_wa = dest_addr;
                    m_rw = (dest_addr != 0);
                end else if (opcode == 4'd8 && MUL_EN) begin
                    p = {32'b0, operand_a} * {32'b0, operand_b};
                    m_mres = p[DW-1:0];
                    m_mdst = dest_addr;
                    m_left = DW;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, rst_n && (m_left == 0));
            chk("busy", busy, (m_left > 0));
            chk("reg_write", reg_write_out, m_rw);
            if (m_rw || !rst_n) begin
                chk("wdata", write_data_out, m_wd);
                chk("waddr", write_address_out, m_wa);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [SW-1:0] d);
        in_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; dest_addr = d;
    endtask

    task automatic wr_check(input string name, input logic [DW-1:0] wd, input logic [SW-1:0] wa);
        @(negedge clk);
        chk({name, "_rw"}, reg_write_out, 1'b1);
        chk({name, "_wd"}, write_data_out, wd);
        chk({name, "_wa"}, write_address_out, wa);
    endtask

    task automatic nowr_check(input string name);
        @(negedge clk);
        chk({name, "_rw"}, reg_write_out, 1'b0);
    endtask

    initial begin
        // Reset held with junk requests present
        drive(4'd0, 32'd1, 32'd2, 5'd5);
        @(posedge clk); #2;
        chk_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_rw", reg_write_out, 1'b0);
            chk("rst_ready", in_ready, 1'b0);
            chk("rst_wd", write_data_out, 32'd0);
            chk("rst_wa", write_address_out, 5'd0);
            chk("rst_busy", busy, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", in_ready, 1'b1);
        tick();

        // Back-to-back ADD, SUB, SLT
        drive(4'd0, 32'd30, 32'd50, 5'd7); tick();
        drive(4'd1, 32'd30, 32'd50, 5'd8);
        wr_check("add", 32'd80, 5'd7); tick();
        drive(4'd5, 32'd30, 32'd50, 5'd9);
        wr_check("sub", 32'hFFFF_FFEC, 5'd8); tick();
        in_valid = 1'b0;
        wr_check("slt", 32'd1, 5'd9); tick();
        nowr_check("b2b_end");

        // Shifts and a NOP opcode
        drive(4'd6, 32'd1, 32'h25, 5'd4); tick(); in_valid = 1'b0;
        wr_check("sll", 32'h20, 5'd4); tick();
        drive(4'd7, 32'h8000_0000, 32'd31, 5'd4); tick(); in_valid = 1'b0;
        wr_check("srl", 32'd1, 5'd4); tick();
        drive(4'd12, 32'd3, 32'd4, 5'd6); tick(); in_valid = 1'b0;
        nowr_check("nop12"); tick();

        // Destination zero never writes
        drive(4'd0, 32'd5, 32'd6, 5'd0); tick(); in_valid = 1'b0;
        nowr_check("dest0"); tick();

`ifdef ALU_EXEC_MUL_EN
        // MUL stall with an ADD held behind it
        drive(4'd8, 32'd30, 32'd50, 5'd10); tick();
        drive(4'd0, 32'd1, 32'd2, 5'd11);
        for (int i = 1; i < DW; i++) begin
            @(negedge clk);
            chk("mul_stall_ready", in_ready, 1'b0);
            chk("mul_stall_busy", busy, 1'b1);
            chk("mul_stall_rw", reg_write_out, 1'b0);
            tick();
        end
        wr_check("mul", 32'd1500, 5'd10);
        chk("mul_pulse_ready", in_ready, 1'b1);
        tick(); in_valid = 1'b0;
        wr_check("held_add", 32'd3, 5'd11); tick();

        drive(4'd8, 32'hFFFF_FFFF, 32'd2, 5'd12); tick(); in_valid = 1'b0;
        repeat (DW - 1) tick();
        wr_check("mul_ff", 32'hFFFF_FFFE, 5'd12); tick();

        // Reset in the middle of a multiply aborts it
        drive(4'd8, 32'd7, 32'd9, 5'd13); tick(); in_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rw", reg_write_out, 1'b0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", in_ready, 1'b1);
        begin
            int pulses = 0;
            repeat (DW + 4) begin
                @(negedge clk);
                if (reg_write_out) pulses++;
            end
            chk("abort_no_write", pulses, 0);
        end
        tick();
`else
        // Opcode 8 is a one-cycle NOP without the multiplier
        drive(4'd8, 32'd30, 32'd50, 5'd10); tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("mul_nop_rw", reg_write_out, 1'b0);
        chk("mul_nop_busy", busy, 1'b0);
        chk("mul_nop_ready", in_ready, 1'b1);
        tick();
`endif

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            logic [DW-1:0] a, b;
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0: a = 32'hFFFF_FFFF;
                1: b = 32'h8000_0000;
                2: a = 32'd0;
                default: ;
            endcase
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            in_valid = ($urandom_range(0, 3) != 0);
            opcode = 4'($urandom_range(0, 15));
            operand_a = a;
            operand_b = b;
            dest_addr = 5'($urandom_range(0, 31));
            tick();
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (DW + 2) tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute/writeback stage directly downstream of the register file.
- Consumes the two read ports (read_data_1/read_data_2) as operands, performs the selected ALU operation, and drives the register file write port (write_data_in, write_address, RegWrite) with a registered result.
- Single-cycle ops complete in one clock. MUL is an iterative shift-add that stalls the stage through a valid/ready handshake.

Parameters:
- data_width, 32, operand/result width; must match the register file data_width.
- select_width, 5, register address width; must match the register file select_width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  stage can accept; combinational = rst_n & (state==IDLE)
- opcode  input  4  operation select
- operand_a  input  data_width  from register file read_data_1
- operand_b  input  data_width  from register file read_data_2
- dest_addr  input  select_width  destination register
- write_data_out  output  data_width  to register file write_data_in
- write_address_out  output  select_width  to register file write_address
- reg_write_out  output  1  to register file RegWrite; one pulse per completed writing op
- busy  output  1  high while in MUL state

Behaviour:
- Reset (async, rst_n low): state=IDLE; write_data_out=0, write_address_out=0, reg_write_out=0, busy=0, multiplier counter/accumulator cleared. A reset mid-MUL aborts the operation and produces no write. Inputs are ignored while rst_n is low.
- Accept: an operation is accepted on a rising edge when in_valid & in_ready.
- Opcodes:
  - 0 ADD, 1 SUB: modulo 2^data_width.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLT: signed compare; result is 1 or 0.
  - 6 SLL, 7 SRL: shift amount = operand_b[4:0]; SRL is logical.
  - 8 MUL: low data_width bits of the unsigned product.
  - 9-15: NOP; accepted, no write.
- Single-cycle op accepted at edge N:
  - write_data_out and write_address_out are registered at edge N.
  - reg_write_out=1 for the cycle following edge N.
  - in_ready stays 1, so back-to-back ops give continuous reg_write_out with a new result each cycle.
- reg_write_out falls to 0 at the next edge unless a new writing op is accepted at that edge.
- Destination 0: if dest_addr==0, reg_write_out stays 0. write_data_out/write_address_out may still update; they are don't-care when reg_write_out=0.
- State machine: IDLE, MUL.
  - IDLE -> MUL on accepting opcode 8. This loads mcand=operand_a, mplier=operand_b, acc=0, cnt=0, and latches dest.
  - In MUL, each edge: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; cnt++.
  - On the edge where cnt==data_width-1, the final step completes, the result is registered, reg_write_out pulses (unless dest==0), and the state returns to IDLE.
  - Latency: accepted at edge N, result visible after edge N+data_width (32 cycles at default). in_ready=0 and busy=1 during cycles N+1 .. N+data_width-1. in_ready=1 in the pulse cycle.
- Operands are sampled only at acceptance. Changes to operand_a/b during MUL have no effect.

Optional Feature:
- ALU_EXEC_MUL_EN:
  - Defined: MUL is implemented as above.
  - Undefined: no multiplier logic or MUL state. Opcode 8 is treated as a NOP (accepted in one cycle, no write), and busy is tied to 0.

Decomposition:
- Package alu_exec_pkg holds:
  - opcode localparams (OP_ADD..OP_MUL);
  - state encodings (S_IDLE, S_MUL);
  - the NOP range bound.
- One sub-module, seq_multiplier: start/done interface holding mcand/mplier/acc/cnt. It is instantiated only under ALU_EXEC_MUL_EN.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> all outputs 0, in_ready=0, no write. Release -> in_ready=1.
- Back-to-back, a=30 b=50 (regfile r3/r5 initial values): ADD dest 7, then SUB dest 8, then SLT dest 9 on consecutive edges -> three consecutive reg_write_out pulses with 80@7, 0xFFFFFFEC@8, 1@9.
- SLL a=1 b=0x25 dest 4 -> write_data_out 0x20 (shift 5). SRL a=0x80000000 b=31 dest 4 -> 1. Opcode 12 -> no write.
- MUL a=30 b=50 dest 10 accepted at edge N -> in_ready=0 for cycles N+1..N+31; single pulse after edge N+32 with 1500@10. An in_valid ADD held during the stall is accepted only once in_ready returns.
- MUL a=0xFFFFFFFF b=2 -> 0xFFFFFFFE. A dest 0 op -> reg_write_out never asserts.
- Assert rst_n=0 at cycle N+10 of a MUL -> no write pulse, state IDLE, in_ready=1 one cycle after release. Without ALU_EXEC_MUL_EN, opcode 8 -> no write, busy=0.
